// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA panel path.
// Holds the frame-packet sync marker, the loader FSM states and plane byte sizing.
package vga_pkg;

  localparam logic [7:0] FRAME_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PENDING
  } loader_state_t;

  // Bytes needed to carry one column of one colour plane.
  function automatic int unsigned frame_bytes_per_plane(input int unsigned height);
    return (height + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Byte link from the MCU receiver plus the VGA frame-start strobe.
// The master modport drives the link; the loader consumes it through the slave modport.
interface frame_loader_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_abort;
  logic       frame_start;

  modport master (
    output rx_byte,
    output rx_valid,
    output rx_abort,
    output frame_start
  );

  modport slave (
    input rx_byte,
    input rx_valid,
    input rx_abort,
    input frame_start
  );
endinterface

// File: rtl/frame_bank.sv
// One board bank: three colour planes with a single masked byte-write port.
// Every cell is readable at once for the renderer.
module frame_bank #(
  parameter int unsigned Width  = 10,
  parameter int unsigned Height = 20,
  parameter int unsigned Bpp    = 3,
  parameter int unsigned XW     = 4,
  parameter int unsigned BW     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         we_i,
  input  logic [XW-1:0]                x_i,
  input  logic [1:0]                   plane_i,
  input  logic [BW-1:0]                byte_i,
  input  logic [7:0]                   data_i,
  output logic [Width-1:0][Height-1:0] red_o,
  output logic [Width-1:0][Height-1:0] green_o,
  output logic [Width-1:0][Height-1:0] blue_o
);

  logic [2:0][Width-1:0][Height-1:0] mem_d, mem_q;

  // Only the rows covered by the addressed byte change; rows past Height are dropped.
  always_comb begin
    mem_d = mem_q;
    if (we_i && (plane_i != 2'd3)) begin
      for (int unsigned b = 0; b < Bpp; b++) begin
        for (int unsigned i = 0; i < 8; i++) begin
          if ((b * 8 + i < Height) && (byte_i == BW'(b))) begin
            mem_d[plane_i][x_i][b * 8 + i] = data_i[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign red_o   = mem_q[0];
  assign green_o = mem_q[1];
  assign blue_o  = mem_q[2];

endmodule

// File: rtl/frame_loader.sv
// Decodes sync-prefixed board packets into the back bank of a double buffer and
// swaps banks only on the VGA frame-start pulse so partial boards are never shown.
module frame_loader
  import vga_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH   = 10,
  parameter int unsigned FRAME_HEIGHT  = 20,
  parameter logic [7:0]  SYNC_BYTE     = FRAME_SYNC_BYTE,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  frame_loader_if.slave                            rx,
  output logic [FRAME_WIDTH-1:0][FRAME_HEIGHT-1:0] frame_R,
  output logic [FRAME_WIDTH-1:0][FRAME_HEIGHT-1:0] frame_G,
  output logic [FRAME_WIDTH-1:0][FRAME_HEIGHT-1:0] frame_B,
  output logic                                     frame_pending,
  output logic                                     frame_swapped,
  output logic [ERR_CNT_WIDTH-1:0]                 err_count
);

  localparam int unsigned BPP = frame_bytes_per_plane(FRAME_HEIGHT);
  localparam int unsigned XW  = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned BW  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [XW-1:0] XLast = XW'(FRAME_WIDTH - 1);
  localparam logic [BW-1:0] BLast = BW'(BPP - 1);

  loader_state_t            state_d, state_q;
  logic [XW-1:0]            x_d, x_q;
  logic [1:0]               plane_d, plane_q;
  logic [BW-1:0]            b_d, b_q;
  logic                     front_sel_d, front_sel_q;
  logic                     swapped_d, swapped_q;
  logic                     overrun_d, overrun_q;
  logic [ERR_CNT_WIDTH-1:0] err_d, err_q;
  logic                     err_inc;
  logic                     wr_en;

  logic [FRAME_WIDTH-1:0][FRAME_HEIGHT-1:0] red0, green0, blue0;
  logic [FRAME_WIDTH-1:0][FRAME_HEIGHT-1:0] red1, green1, blue1;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    plane_d     = plane_q;
    b_d         = b_q;
    front_sel_d = front_sel_q;
    swapped_d   = 1'b0;
    overrun_d   = overrun_q;
    err_inc     = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx.rx_valid && (rx.rx_byte == SYNC_BYTE)) begin
          state_d = LOAD;
          x_d     = '0;
          plane_d = '0;
          b_d     = '0;
        end
      end
      LOAD: begin
        // Abort wins over a byte arriving in the same cycle; the partial bank stays hidden.
        if (rx.rx_abort) begin
          state_d = IDLE;
          err_inc = 1'b1;
        end else if (rx.rx_valid) begin
          wr_en = 1'b1;
          if (b_q == BLast) begin
            b_d = '0;
            if (plane_q == 2'd2) begin
              plane_d = '0;
              if (x_q == XLast) begin
                state_d   = PENDING;
                overrun_d = 1'b0;
              end else begin
                x_d = x_q + XW'(1);
              end
            end else begin
              plane_d = plane_q + 2'd1;
            end
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      PENDING: begin
        if (rx.rx_valid && !overrun_q) begin
          overrun_d = 1'b1;
          err_inc   = 1'b1;
        end
        if (rx.frame_start) begin
          front_sel_d = ~front_sel_q;
          swapped_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = (err_inc && (err_q != '1)) ? err_q + ERR_CNT_WIDTH'(1) : err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      plane_q     <= '0;
      b_q         <= '0;
      front_sel_q <= 1'b0;
      swapped_q   <= 1'b0;
      overrun_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      plane_q     <= plane_d;
      b_q         <= b_d;
      front_sel_q <= front_sel_d;
      swapped_q   <= swapped_d;
      overrun_q   <= overrun_d;
      err_q       <= err_d;
    end
  end

  // The back bank is whichever one is not on screen.
  frame_bank #(
    .Width (FRAME_WIDTH),
    .Height(FRAME_HEIGHT),
    .Bpp   (BPP),
    .XW    (XW),
    .BW    (BW)
  ) u_bank0 (
    .clk_i  (clk),
    .rst_ni (reset),
    .we_i   (wr_en && front_sel_q),
    .x_i    (x_q),
    .plane_i(plane_q),
    .byte_i (b_q),
    .data_i (rx.rx_byte),
    .red_o  (red0),
    .green_o(green0),
    .blue_o (blue0)
  );

  frame_bank #(
    .Width (FRAME_WIDTH),
    .Height(FRAME_HEIGHT),
    .Bpp   (BPP),
    .XW    (XW),
    .BW    (BW)
  ) u_bank1 (
    .clk_i  (clk),
    .rst_ni (reset),
    .we_i   (wr_en && !front_sel_q),
    .x_i    (x_q),
    .plane_i(plane_q),
    .byte_i (b_q),
    .data_i (rx.rx_byte),
    .red_o  (red1),
    .green_o(green1),
    .blue_o (blue1)
  );

  always_comb begin
    frame_R = front_sel_q ? red1   : red0;
    frame_G = front_sel_q ? green1 : green0;
    frame_B = front_sel_q ? blue1  : blue0;
  end

  assign frame_pending = (state_q == PENDING);
  assign frame_swapped = swapped_q;
  assign err_count     = err_q;

endmodule
